// File: rtl/dual_read_data_ram_pkg.sv
// Shared MiniAlu definitions: default datapath widths and controller opcodes.
// The ROM, the FFD pipeline registers, the ALU and the data RAM all use these.
`timescale 1ns/1ps

package dual_read_data_ram_pkg;

    localparam int MINIALU_DATA_WIDTH = 16;
    localparam int MINIALU_ADDR_WIDTH = 8;

    // Instruction opcodes, decoded by the controller only
    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ADD  = 3'd1,
        OP_STO  = 3'd2,
        OP_BLE  = 3'd3,
        OP_JMP  = 3'd4,
        OP_LED  = 3'd5,
        OP_MULU = 3'd6,
        OP_MULS = 3'd7
    } opcode_t;

endpackage

// File: rtl/dual_read_data_ram_ffd.sv
// Generic enabled register with asynchronous active-low clear; one per RAM word.
`timescale 1ns/1ps

module ffd_async_reset_en #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             iEnable,
    input  logic [WIDTH-1:0] iD,
    output logic [WIDTH-1:0] oQ
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            data_q <= '0;
        end else if (iEnable) begin
            data_q <= iD;
        end
    end

    assign oQ = data_q;

endmodule

// File: rtl/dual_read_data_ram.sv
// MiniAlu data memory: two zero-latency read ports, one write port that can
// also store the high product word at the following (wrapping) address.
`timescale 1ns/1ps

module dual_read_data_ram
    import dual_read_data_ram_pkg::*;
#(
    parameter int DATA_WIDTH = MINIALU_DATA_WIDTH,
    parameter int ADDR_WIDTH = MINIALU_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iReadAddress0,
    input  logic [ADDR_WIDTH-1:0] iReadAddress1,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iMulEnable,
    input  logic [DATA_WIDTH-1:0] iParteAlta,
    output logic [DATA_WIDTH-1:0] oDataOut0,
    output logic [DATA_WIDTH-1:0] oDataOut1
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] highAddress;
    logic                  highWrite;

    // Natural overflow of the adder gives the 0xFF -> 0x00 wrap for free
    assign highAddress = iWriteAddress + ADDR_WIDTH'(1);
    assign highWrite   = iWriteEnable & iMulEnable;

    for (genvar i = 0; i < DEPTH; i++) begin : gWord
        logic                  lowHit;
        logic                  highHit;
        logic                  wordEnable;
        logic [DATA_WIDTH-1:0] wordData;

        // The two targets are always distinct, so at most one hit per word
        assign lowHit     = iWriteEnable && (iWriteAddress == ADDR_WIDTH'(i));
        assign highHit    = highWrite && (highAddress == ADDR_WIDTH'(i));
        assign wordEnable = lowHit | highHit;
        assign wordData   = lowHit ? iDataIn : iParteAlta;

        ffd_async_reset_en #(
            .WIDTH (DATA_WIDTH)
        ) uWord (
            .Clock   (Clock),
            .Reset   (Reset),
            .iEnable (wordEnable),
            .iD      (wordData),
            .oQ      (mem_q[i])
        );
    end

    assign oDataOut0 = mem_q[iReadAddress0];
    assign oDataOut1 = mem_q[iReadAddress1];

endmodule

// File: tb/tb_dual_read_data_ram.sv
// Directed self-checking bench for the MiniAlu dual-read data RAM.
`timescale 1ns/1ps

module tb_dual_read_data_ram;

    logic        Clock;
    logic        Reset;
    logic        iWriteEnable;
    logic [7:0]  iReadAddress0;
    logic [7:0]  iReadAddress1;
    logic [7:0]  iWriteAddress;
    logic [15:0] iDataIn;
    logic        iMulEnable;
    logic [15:0] iParteAlta;
    logic [15:0] oDataOut0;
    logic [15:0] oDataOut1;

    int compared   = 0;
    int mismatched = 0;

    dual_read_data_ram dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iWriteEnable  (iWriteEnable),
        .iReadAddress0 (iReadAddress0),
        .iReadAddress1 (iReadAddress1),
        .iWriteAddress (iWriteAddress),
        .iDataIn       (iDataIn),
        .iMulEnable    (iMulEnable),
        .iParteAlta    (iParteAlta),
        .oDataOut0     (oDataOut0),
        .oDataOut1     (oDataOut1)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", tag, observed, expected);
        end
    endtask

    // One write cycle: drive at the falling edge, commit at the rising edge
    task automatic applyStimulus(input logic we, input logic [7:0] addr,
                                 input logic [15:0] data, input logic mul,
                                 input logic [15:0] hi);
        @(negedge Clock);
        iWriteEnable  = we;
        iWriteAddress = addr;
        iDataIn       = data;
        iMulEnable    = mul;
        iParteAlta    = hi;
        @(posedge Clock);
        #1;
        iWriteEnable = 1'b0;
        iMulEnable   = 1'b0;
    endtask

    task automatic readPair(input logic [7:0] a0, input logic [7:0] a1);
        iReadAddress0 = a0;
        iReadAddress1 = a1;
        #1;
    endtask

    initial begin
        Reset         = 1'b0;
        iWriteEnable  = 1'b0;
        iReadAddress0 = 8'h00;
        iReadAddress1 = 8'h05;
        iWriteAddress = 8'h00;
        iDataIn       = 16'h0000;
        iMulEnable    = 1'b0;
        iParteAlta    = 16'h0000;
        #2;
        checkOutput("reset_out0", oDataOut0, 16'h0000);
        checkOutput("reset_out1", oDataOut1, 16'h0000);

        applyStimulus(1'b1, 8'h02, 16'hAAAA, 1'b0, 16'h0000);
        readPair(8'h02, 8'h03);
        checkOutput("write_in_reset", oDataOut0, 16'h0000);

        @(negedge Clock);
        Reset = 1'b1;

        applyStimulus(1'b1, 8'h05, 16'h1234, 1'b0, 16'h0000);
        readPair(8'h05, 8'h02);
        checkOutput("pre_reset_wr5", oDataOut0, 16'h1234);
        checkOutput("no_late_wr2", oDataOut1, 16'h0000);
        #1;
        Reset = 1'b0;
        #1;
        checkOutput("async_clear5", oDataOut0, 16'h0000);
        @(negedge Clock);
        Reset = 1'b1;

        applyStimulus(1'b1, 8'h03, 16'h00AA, 1'b0, 16'h0000);
        applyStimulus(1'b1, 8'h04, 16'h5555, 1'b0, 16'h0000);
        readPair(8'h03, 8'h04);
        checkOutput("dual_rd_a3", oDataOut0, 16'h00AA);
        checkOutput("dual_rd_a4", oDataOut1, 16'h5555);
        readPair(8'h04, 8'h03);
        checkOutput("swap_rd0", oDataOut0, 16'h5555);
        checkOutput("swap_rd1", oDataOut1, 16'h00AA);
        readPair(8'h03, 8'h03);
        checkOutput("same_addr0", oDataOut0, 16'h00AA);
        checkOutput("same_addr1", oDataOut1, 16'h00AA);

        applyStimulus(1'b1, 8'h10, 16'h0001, 1'b1, 16'hFFFE);
        readPair(8'h10, 8'h11);
        checkOutput("mul_low", oDataOut0, 16'h0001);
        checkOutput("mul_high", oDataOut1, 16'hFFFE);
        readPair(8'h12, 8'h0F);
        checkOutput("mul_no_spill12", oDataOut0, 16'h0000);
        checkOutput("mul_no_spill0F", oDataOut1, 16'h0000);

        applyStimulus(1'b1, 8'hFF, 16'hBEEF, 1'b1, 16'hCAFE);
        readPair(8'hFF, 8'h00);
        checkOutput("wrap_low", oDataOut0, 16'hBEEF);
        checkOutput("wrap_high", oDataOut1, 16'hCAFE);

        applyStimulus(1'b0, 8'h07, 16'h7777, 1'b1, 16'h7777);
        readPair(8'h07, 8'h08);
        checkOutput("wdis_a7", oDataOut0, 16'h0000);
        checkOutput("wdis_a8", oDataOut1, 16'h0000);

        applyStimulus(1'b1, 8'h20, 16'h1111, 1'b0, 16'h9999);
        readPair(8'h20, 8'h21);
        checkOutput("plain_a20", oDataOut0, 16'h1111);
        checkOutput("plain_no_hi", oDataOut1, 16'h0000);

        applyStimulus(1'b1, 8'h09, 16'h0011, 1'b0, 16'h0000);
        readPair(8'h09, 8'h10);
        @(negedge Clock);
        iWriteEnable  = 1'b1;
        iWriteAddress = 8'h09;
        iDataIn       = 16'h0022;
        iMulEnable    = 1'b0;
        #1;
        checkOutput("rdw_before", oDataOut0, 16'h0011);
        @(posedge Clock);
        #1;
        iWriteEnable = 1'b0;
        checkOutput("rdw_after", oDataOut0, 16'h0022);
        checkOutput("rdw_other", oDataOut1, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dual_read_data_ram.md
Name: dual_read_data_ram

Overview:
- Data memory for the MiniAlu datapath: 256 x 16-bit array with two combinational read ports and one synchronous write port.
- Sources ALU operands (read ports 0/1) and stores the ALU result.
- Multiply operations write the low product word to the destination and the high product word to destination+1 in the same cycle.

Parameters:
- DATA_WIDTH, 16, word width of every entry and data port.
- ADDR_WIDTH, 8, address width; depth = 2**ADDR_WIDTH (256).

Ports:
- Clock  input  1  single clock; all writes on rising edge.
- Reset  input  1  asynchronous, active-low reset (Reset=0 resets); clock and reset named as in the codebase.
- iWriteEnable  input  1  write strobe, sampled at rising Clock.
- iReadAddress0  input  ADDR_WIDTH  read port 0 address.
- iReadAddress1  input  ADDR_WIDTH  read port 1 address.
- iWriteAddress  input  ADDR_WIDTH  write address (low word for multiply).
- iDataIn  input  DATA_WIDTH  write data (low product word for multiply).
- iMulEnable  input  1  qualifies a dual write of the high product word.
- iParteAlta  input  DATA_WIDTH  high product word.
- oDataOut0  output  DATA_WIDTH  contents of mem[iReadAddress0].
- oDataOut1  output  DATA_WIDTH  contents of mem[iReadAddress1].

Behaviour:
- Reset=0 (asynchronous, independent of Clock): every entry cleared to 0 immediately. oDataOut0/1 read 0 while Reset is held.
- Writes are ignored while Reset=0. Reset deasserts synchronously in effect: the first write is possible at the first rising edge after Reset=1.
- Read ports are purely combinational, with zero latency.
  - oDataOutN = mem[iReadAddressN] at all times.
  - Both ports may address the same or any entries independently.
- Normal write: at rising Clock with Reset=1, iWriteEnable=1, iMulEnable=0, mem[iWriteAddress] <= iDataIn.
- Multiply write: at rising Clock with Reset=1, iWriteEnable=1, iMulEnable=1, both of the following occur in the same edge:
  - mem[iWriteAddress] <= iDataIn
  - mem[(iWriteAddress+1) mod 256] <= iParteAlta
- Address wrap: iWriteAddress=0xFF with iMulEnable=1 writes the high word to address 0x00.
- iMulEnable=1 with iWriteEnable=0: no write at all.
- Read-during-write: no bypass.
  - Before the edge, outputs show the old contents.
  - After the edge, outputs show the new data combinationally.
- iParteAlta and iMulEnable are don't-care when iWriteEnable=0 or iMulEnable=0.
- No X propagation from unwritten entries: every entry is defined as 0 after reset.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/ADDR_WIDTH defaults (16/8), shared with the ROM, the FFD pipeline registers and the ALU.
  - Opcode constants (NOP, ADD, STO, BLE, JMP, LED, MULU, MULS), used by the controller, not by this block.
- The storage array and write-decode logic live in this module. No sub-module is needed.
- The optional generic register cell (async active-low reset, enable) may be factored as ffd_async_reset_en if the team prefers flop-based storage.

Test Plan:
- Reset: write 0x1234 to addr 5, then pulse Reset=0 mid-cycle -> oDataOut0 at addr 5 reads 0x0000 immediately, without waiting for a clock edge.
- Basic write/dual read: write 0x00AA to addr 3 and 0x5555 to addr 4; set read addresses to 3/4 -> oDataOut0=0x00AA, oDataOut1=0x5555. Swap the addresses -> outputs swap in the same cycle.
- Multiply write: iWriteAddress=0x10, iDataIn=0x0001, iParteAlta=0xFFFE, iMulEnable=1, iWriteEnable=1 -> addr 0x10=0x0001, addr 0x11=0xFFFE.
- Multiply wrap: iWriteAddress=0xFF, iDataIn=0xBEEF, iParteAlta=0xCAFE -> addr 0xFF=0xBEEF, addr 0x00=0xCAFE.
- Write disabled: iWriteEnable=0, iMulEnable=1, addr 7, data 0x7777 -> addr 7 and addr 8 remain 0x0000.
- Read-during-write: read addr 9 (holding 0x0011) while writing 0x0022 to addr 9 -> output 0x0011 before the edge, 0x0022 after the edge.
